// File: rtl/seg_disp_pkg.sv
// Shared types and segment patterns for the multiplexed 7-segment display scanner.
// Segment bit order is {a,b,c,d,e,f,g}, active-high.
package seg_disp_pkg;

   typedef enum logic {
      S_DRIVE = 1'b0,
      S_BLANK = 1'b1
   } state_t;

   localparam int NUM_DIGITS = 4;

   localparam logic [6:0] SEG_0    = 7'b1111110;
   localparam logic [6:0] SEG_1    = 7'b0110000;
   localparam logic [6:0] SEG_2    = 7'b1101101;
   localparam logic [6:0] SEG_3    = 7'b1111001;
   localparam logic [6:0] SEG_4    = 7'b0110011;
   localparam logic [6:0] SEG_5    = 7'b1011011;
   localparam logic [6:0] SEG_6    = 7'b1011111;
   localparam logic [6:0] SEG_7    = 7'b1110000;
   localparam logic [6:0] SEG_8    = 7'b1111111;
   localparam logic [6:0] SEG_9    = 7'b1111011;
   localparam logic [6:0] SEG_DASH = 7'b0000001;
   localparam logic [6:0] SEG_OFF  = 7'b0000000;

   // Active-low one-hot digit enable for the given digit index.
   function automatic logic [3:0] digit_enable(input logic [1:0] idx);
      return ~(4'b0001 << idx);
   endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to 7-segment decoder; non-BCD codes render as a dash.
module bcd_to_seg
   import seg_disp_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Scan scheduler for a 4-digit multiplexed 7-segment display with shadow/active
// digit buffers; new digits reach the pins only at a frame boundary.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_DRIVE | digit idx is driven for SCAN_CYCLES cycles
// S_BLANK | all digits off for DEAD_CYCLES cycles before moving to idx+1
module seg_scan_ctrl
   import seg_disp_pkg::*;
#(
   parameter int SCAN_CYCLES = 50000,
   parameter int DEAD_CYCLES = 16,
   parameter int CNT_W       = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_valid,
   output logic       wr_ready,
   input  logic [1:0] wr_idx,
   input  logic [3:0] wr_val,
   input  logic       commit,
   output logic       commit_pending,
   output logic       frame_done,
   input  logic       blank_en,
   output logic [6:0] seg,
   output logic [3:0] digit_select
);

   localparam bit               HAS_DEAD  = (DEAD_CYCLES > 0);
   localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
   localparam logic [CNT_W-1:0] DEAD_LAST = HAS_DEAD ? CNT_W'(DEAD_CYCLES - 1) : '0;

   state_t                           state, state_nxt;
   logic [1:0]                       idx, idx_nxt;
   logic [CNT_W-1:0]                 cnt, cnt_nxt;
   logic                             advance;
   logic                             boundary;
   logic [NUM_DIGITS-1:0][3:0]       shadow;
   logic [NUM_DIGITS-1:0][3:0]       active;
   logic [6:0]                       seg_dec;
   logic                             wr_fire;

   assign wr_ready = !commit_pending;
   assign wr_fire  = wr_valid && wr_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_DRIVE;
         idx   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      cnt_nxt   = cnt + CNT_W'(1);
      advance   = 1'b0;
      case (state)
         S_DRIVE: begin
            if (cnt == SCAN_LAST) begin
               cnt_nxt = '0;
               if (HAS_DEAD) begin
                  state_nxt = S_BLANK;
               end else begin
                  advance = 1'b1;
               end
            end
         end
         S_BLANK: begin
            if (cnt == DEAD_LAST) begin
               cnt_nxt   = '0;
               advance   = 1'b1;
               state_nxt = S_DRIVE;
            end
         end
         default: begin
            state_nxt = S_DRIVE;
            cnt_nxt   = '0;
         end
      endcase
      if (advance) begin
         idx_nxt = idx + 2'd1;
      end
      boundary = advance && (idx == 2'd3);
   end

   // A commit raised on the boundary edge itself is not yet pending there, so it
   // lands at the next boundary; writes are blocked while pending, so the
   // snapshot below never races a shadow write.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shadow         <= {NUM_DIGITS{4'hF}};
         active         <= {NUM_DIGITS{4'hF}};
         commit_pending <= 1'b0;
         frame_done     <= 1'b0;
      end else begin
         frame_done <= boundary;
         if (boundary && commit_pending) begin
            active         <= shadow;
            commit_pending <= 1'b0;
         end else if (commit && !commit_pending) begin
            commit_pending <= 1'b1;
         end
         if (wr_fire) begin
            shadow[wr_idx] <= wr_val;
         end
      end
   end

   bcd_to_seg u_dec (
      .bcd (active[idx]),
      .seg (seg_dec)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seg          <= SEG_OFF;
         digit_select <= 4'b1111;
      end else if (state == S_DRIVE && !blank_en) begin
         seg          <= seg_dec;
         digit_select <= digit_enable(idx);
      end else begin
         seg          <= SEG_OFF;
         digit_select <= 4'b1111;
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with SCAN_CYCLES=4, DEAD_CYCLES=2.
// The reference model works on the frame timeline: position within a 24-cycle frame.
module tb_seg_scan_ctrl;

   localparam int SCAN  = 4;
   localparam int DEAD  = 2;
   localparam int SLOT  = SCAN + DEAD;
   localparam int FRAME = 4 * SLOT;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wr_valid;
   logic       wr_ready;
   logic [1:0] wr_idx;
   logic [3:0] wr_val;
   logic       commit;
   logic       commit_pending;
   logic       frame_done;
   logic       blank_en;
   logic [6:0] seg;
   logic [3:0] digit_select;

   always #5 clk = ~clk;

   seg_scan_ctrl #(
      .SCAN_CYCLES (SCAN),
      .DEAD_CYCLES (DEAD),
      .CNT_W       (4)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .wr_valid       (wr_valid),
      .wr_ready       (wr_ready),
      .wr_idx         (wr_idx),
      .wr_val         (wr_val),
      .commit         (commit),
      .commit_pending (commit_pending),
      .frame_done     (frame_done),
      .blank_en       (blank_en),
      .seg            (seg),
      .digit_select   (digit_select)
   );

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [3:0] m_shadow [4];
   logic [3:0] m_active [4];
   bit         m_pend;
   int         k;
   logic [6:0] e_seg;
   logic [3:0] e_dsel;
   bit         e_fd;
   bit         last_acc;
   logic [3:0] wvals [4];

   function automatic logic [6:0] ref_decode(input logic [3:0] v);
      case (v)
         4'd0: return 7'b1111110;
         4'd1: return 7'b0110000;
         4'd2: return 7'b1101101;
         4'd3: return 7'b1111001;
         4'd4: return 7'b0110011;
         4'd5: return 7'b1011011;
         4'd6: return 7'b1011111;
         4'd7: return 7'b1110000;
         4'd8: return 7'b1111111;
         4'd9: return 7'b1111011;
         default: return 7'b0000001;
      endcase
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h k=%0d", tag, obs, expv, k);
      end
   endtask

   // Advance the model by one clock using the inputs the DUT sees at this edge,
   // then compare all outputs just after the edge.
   task automatic tick();
      int p;
      int d;
      bit drv;
      bit bnd;
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            m_shadow[i] = 4'hF;
            m_active[i] = 4'hF;
         end
         m_pend   = 1'b0;
         k        = 0;
         e_seg    = 7'b0;
         e_dsel   = 4'hF;
         e_fd     = 1'b0;
         last_acc = 1'b0;
      end else begin
         p   = k % FRAME;
         d   = p / SLOT;
         drv = ((p % SLOT) < SCAN) && !blank_en;
         bnd = (p == FRAME - 1);
         e_seg  = drv ? ref_decode(m_active[d]) : 7'b0;
         e_dsel = drv ? ~(4'b0001 << d) : 4'hF;
         e_fd   = bnd;
         last_acc = wr_valid && !m_pend;
         if (bnd && m_pend) begin
            m_active = m_shadow;
            m_pend   = 1'b0;
         end else if (commit && !m_pend) begin
            m_pend = 1'b1;
         end
         if (last_acc) m_shadow[wr_idx] = wr_val;
         k++;
      end
      @(posedge clk);
      #1;
      check("seg",            {1'b0, seg},          {1'b0, e_seg});
      check("digit_select",   {4'b0, digit_select}, {4'b0, e_dsel});
      check("frame_done",     {7'b0, frame_done},   {7'b0, e_fd});
      check("commit_pending", {7'b0, commit_pending}, {7'b0, m_pend});
      check("wr_ready",       {7'b0, wr_ready},     {7'b0, !m_pend});
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic write_digit(input logic [1:0] i, input logic [3:0] v);
      wr_valid = 1'b1;
      wr_idx   = i;
      wr_val   = v;
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic do_commit();
      commit = 1'b1;
      tick();
      commit = 1'b0;
   endtask

   initial begin
      rst_n    = 1'b0;
      wr_valid = 1'b0;
      wr_idx   = '0;
      wr_val   = '0;
      commit   = 1'b0;
      blank_en = 1'b0;
      k        = 0;
      wvals[0] = 4'd1;
      wvals[1] = 4'd2;
      wvals[2] = 4'd3;
      wvals[3] = 4'd9;

      // reset and free-running dashes
      run(3);
      rst_n = 1'b1;
      run(30);

      // write 1,2,3,9 then commit
      for (int i = 0; i < 4; i++) write_digit(2'(i), wvals[i]);
      do_commit();
      run(50);

      // stall: write held while a commit is pending
      do_commit();
      wr_valid = 1'b1;
      wr_idx   = 2'd0;
      wr_val   = 4'd5;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (last_acc) break;
      end
      check("stall_accept", {7'b0, last_acc}, 8'd1);
      wr_valid = 1'b0;
      run(30);
      do_commit();
      run(50);

      // simultaneous write and commit
      wr_valid = 1'b1;
      wr_idx   = 2'd2;
      wr_val   = 4'd7;
      commit   = 1'b1;
      tick();
      wr_valid = 1'b0;
      commit   = 1'b0;
      run(50);

      // blanking for more than a frame
      blank_en = 1'b1;
      run(30);
      blank_en = 1'b0;
      run(6);

      // invalid code shows a dash
      write_digit(2'd1, 4'hC);
      do_commit();
      run(50);

      // randomized traffic, honouring the hold-while-not-ready rule
      for (int n = 0; n < 400; n++) begin
         if (!(wr_valid && m_pend)) begin
            wr_valid = ($urandom_range(0, 3) == 0);
            wr_idx   = 2'($urandom_range(0, 3));
            wr_val   = 4'($urandom_range(0, 15));
         end
         commit   = ($urandom_range(0, 9) == 0);
         blank_en = ($urandom_range(0, 19) == 0);
         tick();
      end
      wr_valid = 1'b0;
      commit   = 1'b0;
      blank_en = 1'b0;
      run(6);

      // mid-frame reset with a commit pending
      write_digit(2'd3, 4'd4);
      do_commit();
      for (int i = 0; i < FRAME && (k % FRAME) != 13; i++) tick();
      check("pending_before_reset", {7'b0, commit_pending}, {7'b0, m_pend});
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      run(30);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
